// File: rtl/vip_matrix_generate_3x3_param.sv
// -----------------------------------------------------------------------------
// vip_matrix_generate_3x3_param
//
// Purpose:
//   Builds a 3x3 pixel neighbourhood from a raster stream for the downstream
//   3x3 kernels (Sobel, median, erosion/dilation). The two previous image
//   lines live in internal read-first line buffers. Missing neighbours at the
//   top rows and left columns are either zero-padded or replicated from the
//   nearest valid pixel. A border flag marks every window that contains a
//   substituted element.
//
// Handshake:
//   A pixel is accepted when per_frame_href && per_frame_clken. There is no
//   back-pressure. Each accept produces exactly one matrix_frame_clken pulse
//   2 cycles later. vsync and href are also delayed by exactly 2 cycles.
//
// Ports:
//   clk                 in   pixel clock
//   rst_n               in   asynchronous active-low reset
//   per_frame_vsync     in   frame sync, active-high
//   per_frame_href      in   line valid
//   per_frame_clken     in   pixel qualifier
//   per_img_y           in   input pixel [DW-1:0]
//   matrix_frame_vsync  out  vsync delayed 2 cycles
//   matrix_frame_href   out  href delayed 2 cycles
//   matrix_frame_clken  out  accept delayed 2 cycles
//   matrix_p11..p33     out  window; row 1 = oldest line, column 3 = newest
//   matrix_border       out  window contains a padded/replicated element
// -----------------------------------------------------------------------------
module vip_matrix_generate_3x3_param #(
  parameter int DW          = 8,
  parameter int IMG_W       = 640,
  parameter int XW          = 10,
  parameter int BORDER_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [DW-1:0] per_img_y,
  output logic          matrix_frame_vsync,
  output logic          matrix_frame_href,
  output logic          matrix_frame_clken,
  output logic [DW-1:0] matrix_p11,
  output logic [DW-1:0] matrix_p12,
  output logic [DW-1:0] matrix_p13,
  output logic [DW-1:0] matrix_p21,
  output logic [DW-1:0] matrix_p22,
  output logic [DW-1:0] matrix_p23,
  output logic [DW-1:0] matrix_p31,
  output logic [DW-1:0] matrix_p32,
  output logic [DW-1:0] matrix_p33,
  output logic          matrix_border
);

  // The column counter has one extra bit so it can hold the saturation value
  // IMG_W even when IMG_W == 2^XW.
  localparam int               CW    = XW + 1;
  localparam int               AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0]    X_SAT = CW'(IMG_W);
  localparam logic [XW-1:0]    Y_SAT = '1;
  localparam bit               REPL  = (BORDER_MODE != 0);

  // ---------------------------------------------------------------------------
  // Input qualification and edge detection
  // ---------------------------------------------------------------------------
  logic accept;
  logic vsync_q;       // vsync delayed 1 cycle (edge detect and sync pipe)
  logic href_q;        // href delayed 1 cycle (edge detect and sync pipe)
  logic vsync_rise;
  logic href_fall;

  assign accept     = per_frame_href && per_frame_clken;
  assign vsync_rise = per_frame_vsync && !vsync_q;
  assign href_fall  = href_q && !per_frame_href;

  // ---------------------------------------------------------------------------
  // Column / row counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] x_cnt_q, x_cnt_d;
  logic [XW-1:0] y_cnt_q, y_cnt_d;
  logic          line_acc_q, line_acc_d;  // at least one accept on this line
  logic          in_range;
  logic          wr_en;
  logic [AW-1:0] addr;

  assign in_range = (x_cnt_q < X_SAT);
  assign wr_en    = accept && in_range;
  assign addr     = x_cnt_q[AW-1:0];

  always_comb begin
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    line_acc_d = line_acc_q;

    // accept and href_fall are mutually exclusive (accept needs href high).
    if (href_fall) begin
      x_cnt_d = '0;
    end else if (wr_en) begin
      x_cnt_d = x_cnt_q + 1'b1;
    end

    if (href_fall) begin
      line_acc_d = 1'b0;
    end else if (accept) begin
      line_acc_d = 1'b1;
    end

    // A vsync rising edge overrides a simultaneous end-of-line increment.
    if (vsync_rise) begin
      y_cnt_d = '0;
    end else if (href_fall && line_acc_q && (y_cnt_q != Y_SAT)) begin
      y_cnt_d = y_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      line_acc_q <= 1'b0;
    end else begin
      vsync_q    <= per_frame_vsync;
      href_q     <= per_frame_href;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      line_acc_q <= line_acc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb1 holds line y-1, lb2 holds line y-2. Writing lb2 with the
  // old lb1 entry in the same cycle rolls both lines forward one column at a
  // time. Contents are deliberately not reset; rows from before the current
  // frame/reset are masked by the row substitution below.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] lb1_mem [IMG_W];
  logic [DW-1:0] lb2_mem [IMG_W];
  logic [DW-1:0] lb1_rd_q;
  logic [DW-1:0] lb2_rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb1_mem[addr] <= per_img_y;
      lb2_mem[addr] <= lb1_mem[addr];
    end
  end

  // Read-first output registers (stage 1 r2 / r1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb1_rd_q <= '0;
      lb2_rd_q <= '0;
    end else if (wr_en) begin
      lb1_rd_q <= lb1_mem[addr];
      lb2_rd_q <= lb2_mem[addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture pixel and its position
  // ---------------------------------------------------------------------------
  logic          s1_acc_q;   // accept delayed 1 cycle
  logic          s1_upd_q;   // accept that updates the window (x in range)
  logic [DW-1:0] s1_pix_q;
  logic [CW-1:0] s1_x_q;
  logic [XW-1:0] s1_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_acc_q <= 1'b0;
      s1_upd_q <= 1'b0;
      s1_pix_q <= '0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
    end else begin
      s1_acc_q <= accept;
      s1_upd_q <= wr_en;
      if (accept) begin
        s1_pix_q <= per_img_y;
        s1_x_q   <= x_cnt_q;
        s1_y_q   <= y_cnt_q;
      end
    end
  end

  // Row substitution for the top two lines of a frame. new_col[0] is row 1
  // (oldest line), new_col[2] is row 3 (current line).
  logic [DW-1:0] new_col [3];

  always_comb begin
    new_col[0] = lb2_rd_q;
    new_col[1] = lb1_rd_q;
    new_col[2] = s1_pix_q;
    if (s1_y_q == '0) begin
      new_col[0] = REPL ? s1_pix_q : '0;
      new_col[1] = REPL ? s1_pix_q : '0;
    end else if (s1_y_q == XW'(1)) begin
      new_col[0] = REPL ? lb1_rd_q : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: window shift register with column substitution
  // win_q[row][col], col 2 is the newest pixel.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] win_q [3][3];
  logic [DW-1:0] win_d [3][3];
  logic          border_q, border_d;

  always_comb begin
    win_d    = win_q;
    border_d = border_q;

    if (!href_q) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_d[r][c] = '0;
        end
      end
      border_d = 1'b0;
    end else if (s1_acc_q) begin
      border_d = (s1_y_q < XW'(2)) || (s1_x_q < CW'(2));
      // Overlong-line accepts (s1_upd_q low) keep the window untouched.
      if (s1_upd_q) begin
        for (int r = 0; r < 3; r++) begin
          if (s1_x_q == '0) begin
            win_d[r][0] = REPL ? new_col[r] : '0;
            win_d[r][1] = REPL ? new_col[r] : '0;
          end else if (s1_x_q == CW'(1)) begin
            win_d[r][0] = REPL ? win_q[r][2] : '0;
            win_d[r][1] = win_q[r][2];
          end else begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
          end
          win_d[r][2] = new_col[r];
        end
      end
    end
  end

  logic out_vsync_q;
  logic out_href_q;
  logic out_clken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      border_q    <= 1'b0;
      out_vsync_q <= 1'b0;
      out_href_q  <= 1'b0;
      out_clken_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      border_q    <= border_d;
      out_vsync_q <= vsync_q;
      out_href_q  <= href_q;
      out_clken_q <= s1_acc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign matrix_frame_vsync = out_vsync_q;
  assign matrix_frame_href  = out_href_q;
  assign matrix_frame_clken = out_clken_q;
  assign matrix_border      = border_q;

  assign matrix_p11 = win_q[0][0];
  assign matrix_p12 = win_q[0][1];
  assign matrix_p13 = win_q[0][2];
  assign matrix_p21 = win_q[1][0];
  assign matrix_p22 = win_q[1][1];
  assign matrix_p23 = win_q[1][2];
  assign matrix_p31 = win_q[2][0];
  assign matrix_p32 = win_q[2][1];
  assign matrix_p33 = win_q[2][2];

endmodule

// File: tb/tb_vip_matrix_generate_3x3_param.sv
// -----------------------------------------------------------------------------
// tb_vip_matrix_generate_3x3_param
//
// Drives one raster stream into two instances (zero-pad and replicate) and
// compares every output of both against a frame-image reference model each
// cycle. The model stores accepted pixels as image[row][col] and builds each
// window directly from neighbour coordinates with clamping or zeroing.
// -----------------------------------------------------------------------------
module tb_vip_matrix_generate_3x3_param;

  localparam int DW    = 8;
  localparam int IMG_W = 4;
  localparam int XW    = 3;
  localparam int WBW   = 9 * DW + 1;  // {border, p11..p33}
  localparam int OW    = 3 + WBW;     // {vsync, href, clken, border, p11..p33}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          vsync, href, clken;
  logic [DW-1:0] pix;

  logic          o0_vs, o0_hr, o0_ce, b0;
  logic          o1_vs, o1_hr, o1_ce, b1;
  logic [DW-1:0] p0 [9];
  logic [DW-1:0] p1 [9];

  vip_matrix_generate_3x3_param #(
    .DW(DW), .IMG_W(IMG_W), .XW(XW), .BORDER_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_y(pix),
    .matrix_frame_vsync(o0_vs), .matrix_frame_href(o0_hr), .matrix_frame_clken(o0_ce),
    .matrix_p11(p0[0]), .matrix_p12(p0[1]), .matrix_p13(p0[2]),
    .matrix_p21(p0[3]), .matrix_p22(p0[4]), .matrix_p23(p0[5]),
    .matrix_p31(p0[6]), .matrix_p32(p0[7]), .matrix_p33(p0[8]),
    .matrix_border(b0)
  );

  vip_matrix_generate_3x3_param #(
    .DW(DW), .IMG_W(IMG_W), .XW(XW), .BORDER_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_y(pix),
    .matrix_frame_vsync(o1_vs), .matrix_frame_href(o1_hr), .matrix_frame_clken(o1_ce),
    .matrix_p11(p1[0]), .matrix_p12(p1[1]), .matrix_p13(p1[2]),
    .matrix_p21(p1[3]), .matrix_p22(p1[4]), .matrix_p23(p1[5]),
    .matrix_p31(p1[6]), .matrix_p32(p1[7]), .matrix_p33(p1[8]),
    .matrix_border(b1)
  );

  logic [WBW-1:0] wb0, wb1;
  logic [OW-1:0]  got0, got1;

  assign wb0  = {b0, p0[0], p0[1], p0[2], p0[3], p0[4], p0[5], p0[6], p0[7], p0[8]};
  assign wb1  = {b1, p1[0], p1[1], p1[2], p1[3], p1[4], p1[5], p1[6], p1[7], p1[8]};
  assign got0 = {o0_vs, o0_hr, o0_ce, wb0};
  assign got1 = {o1_vs, o1_hr, o1_ce, wb1};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [OW-1:0] exp_q0[$];
  logic [OW-1:0] exp_q1[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [OW-1:0] got,
                           input logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: frame image plus counters
  // ---------------------------------------------------------------------------
  logic [DW-1:0]  img [8][IMG_W];
  int             mx, my;
  bit             mhad, mvs_prev, mhr_prev;
  logic [WBW-1:0] hold_wb [2];

  function automatic logic [DW-1:0] ref_px(input int mode, input int ry, input int cx);
    int yy, xx;
    if (mode == 0 && (ry < 0 || cx < 0)) return '0;
    yy = (ry < 0) ? 0 : ry;
    xx = (cx < 0) ? 0 : cx;
    return img[yy][xx];
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mhad = 0; mvs_prev = 0; mhr_prev = 0;
    hold_wb[0] = '0; hold_wb[1] = '0;
    exp_q0.delete(); exp_q1.delete();
    // Outputs for the two cycles already in flight after reset are idle.
    repeat (2) begin
      exp_q0.push_back('0);
      exp_q1.push_back('0);
    end
  endtask

  task automatic model_step(input bit vs, input bit hr, input bit ce,
                            input logic [DW-1:0] px);
    bit acc;
    logic [9*DW-1:0] w;
    logic [WBW-1:0]  wb [2];
    acc = hr && ce;
    if (acc && mx < IMG_W) img[my][mx] = px;
    for (int m = 0; m < 2; m++) begin
      if (!hr) begin
        wb[m] = '0;
      end else if (acc) begin
        if (mx < IMG_W) begin
          w = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              w = {w[8*DW-1:0], ref_px(m, my - 2 + r, mx - 2 + c)};
        end else begin
          w = hold_wb[m][9*DW-1:0];
        end
        wb[m] = {(my < 2) || (mx < 2), w};
      end else begin
        wb[m] = hold_wb[m];
      end
      hold_wb[m] = wb[m];
    end
    exp_q0.push_back({vs, hr, acc, wb[0]});
    exp_q1.push_back({vs, hr, acc, wb[1]});

    if (acc) begin
      if (mx < IMG_W) mx++;
      mhad = 1;
    end
    if (vs && !mvs_prev) my = 0;
    else if (mhr_prev && !hr && mhad) my = (my == 7) ? 7 : my + 1;
    if (mhr_prev && !hr) begin
      mx = 0;
      mhad = 0;
    end
    mvs_prev = vs;
    mhr_prev = hr;
  endtask

  // ---------------------------------------------------------------------------
  // Known-answer windows for the first, gap-free frame
  // ---------------------------------------------------------------------------
  bit kat_on  = 0;
  int kat_idx = 0;

  function automatic logic [WBW-1:0] kw(input bit bd, input int a, input int b,
      input int c, input int d, input int e, input int f, input int g,
      input int h, input int i);
    return {bd, DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g), DW'(h), DW'(i)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit vs, input bit hr, input bit ce,
                       input logic [DW-1:0] px);
    @(negedge clk);
    check_vec("dut0_out", got0, exp_q0.pop_front());
    check_vec("dut1_out", got1, exp_q1.pop_front());
    if (kat_on && o0_ce) begin
      case (kat_idx)
        0: begin
          check_vec("kat0_y0x0", OW'(wb0), OW'(kw(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
          check_vec("kat1_y0x0", OW'(wb1), OW'(kw(1, 1, 1, 1, 1, 1, 1, 1, 1, 1)));
        end
        5:  check_vec("kat1_y1x1", OW'(wb1), OW'(kw(1, 1, 1, 2, 1, 1, 2, 17, 17, 18)));
        10: check_vec("kat0_y2x2", OW'(wb0), OW'(kw(0, 1, 2, 3, 17, 18, 19, 33, 34, 35)));
        default: ;
      endcase
      kat_idx++;
    end
    vsync = vs; href = hr; clken = ce; pix = px;
    model_step(vs, hr, ce, px);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, '0);
  endtask

  task automatic vsync_pulse();
    repeat (3) cycle(1, 0, 0, '0);
    idle(3);
  endtask

  // One line of n_acc accepted pixels; gap_pct is the chance of a clken gap.
  task automatic line(input int y, input int n_acc, input int gap_pct,
                      input bit rand_pix);
    int acc_n = 0;
    int guard = 0;
    bit ce;
    logic [DW-1:0] v;
    while (acc_n < n_acc && guard < 400) begin
      ce = ($urandom_range(0, 99) >= gap_pct);
      if (ce) v = rand_pix ? DW'($urandom) : DW'(16 * y + acc_n + 1);
      else    v = DW'($urandom);
      cycle(0, 1, ce, v);
      if (ce) acc_n++;
      guard++;
    end
    if (acc_n < n_acc) begin
      n_vec++; n_err++;
      $display("FAIL line_stim y=%0d accepted=%0d wanted=%0d", y, acc_n, n_acc);
    end
    repeat ($urandom_range(0, 2)) cycle(0, 1, 0, DW'($urandom));
    idle(3);
  endtask

  task automatic frame(input int nlines, input int gap_pct, input bit rand_pix);
    vsync_pulse();
    for (int y = 0; y < nlines; y++) line(y, IMG_W, gap_pct, rand_pix);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_dut0"}, got0, '0);
    check_vec({tag, "_dut1"}, got1, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    vsync = 0; href = 0; clken = 0; pix = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    model_reset();
    idle(4);

    // Gap-free frame with known-answer windows
    kat_on = 1;
    frame(3, 0, 0);
    idle(4);
    kat_on = 0;
    check_vec("kat_count", OW'(kat_idx), OW'(3 * IMG_W));

    // Same stream with random clken gaps
    frame(3, 50, 0);

    // Overlong line, then a line that must still see the untouched RAM,
    // then a single-accept line closing the frame
    vsync_pulse();
    line(0, IMG_W, 20, 0);
    line(1, IMG_W + 2, 20, 0);
    line(2, IMG_W, 20, 0);
    line(3, 1, 0, 0);

    // Random frames
    for (int f = 0; f < 3; f++) frame($urandom_range(3, 5), $urandom_range(0, 60), 1);

    // Reset during line 2 of a frame
    vsync_pulse();
    line(0, IMG_W, 30, 1);
    line(1, IMG_W, 30, 1);
    cycle(0, 1, 1, DW'($urandom));
    cycle(0, 1, 1, DW'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    vsync = 0; href = 0; clken = 0; pix = '0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
    rst_n = 1'b1;
    model_reset();
    idle(2);

    // Fresh frame after reset: stale RAM rows must not appear
    frame(4, 30, 1);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vip_matrix_generate_3x3_param.md
Name: vip_matrix_generate_3x3_param

Overview:
Parametrised 3x3 neighbourhood generator for the VIP filter chain (Sobel, median, erosion/dilation front-end).
- Takes a raster pixel stream qualified by vsync/href/clken.
- Holds the two previous image lines in internal line-buffer RAMs, so no external shift RAM is needed.
- Emits a 3x3 window per accepted pixel, with selectable border handling (zero-pad or edge-replicate) and a border flag.
- Sits between the colour-space converter and any 3x3 kernel.

Parameters:
DW, 8, pixel data width in bits.
IMG_W, 640, active pixels per line (line-buffer depth).
XW, 10, column/row counter width; must satisfy 2^XW >= IMG_W.
BORDER_MODE, 0, 0 = zero-pad missing neighbours; 1 = replicate nearest valid pixel.

Ports:
clk  in  1  pixel clock.
rst_n  in  1  reset; asynchronous, active-low.
per_frame_vsync  in  1  frame sync, active-high.
per_frame_href  in  1  line valid.
per_frame_clken  in  1  pixel qualifier; pixel accepted when href && clken.
per_img_y  in  DW  input pixel.
matrix_frame_vsync  out  1  vsync delayed 2 cycles.
matrix_frame_href  out  1  href delayed 2 cycles.
matrix_frame_clken  out  1  accept (href && clken) delayed 2 cycles.
matrix_p11..matrix_p33  out  DW each  window; row1 = oldest line, column 3 = newest pixel.
matrix_border  out  1  high when the window contains any substituted (padded/replicated) element; aligned with matrix_frame_clken.

Behaviour:
- Reset (async, rst_n low): all outputs 0, x/y counters 0, all pipeline registers 0. Line-buffer RAM contents are not cleared; they are masked by y = 0 after reset.
- Column counter x:
  - Increments on each accept.
  - Clears on href falling edge.
  - Saturates at IMG_W; accepts with x >= IMG_W do not write the RAM and produce matrix_frame_clken with the window held.
- Row counter y:
  - Increments on href falling edge when at least one pixel was accepted on that line.
  - Clears on vsync rising edge; saturates at 2^XW-1.
  - vsync rising and href falling in the same cycle: clear wins.
- Line buffers (lb1 = line y-1, lb2 = line y-2): read-first synchronous RAM, depth IMG_W. On accept at column x: read lb1[x] and lb2[x]; write lb1[x] <= pixel and lb2[x] <= old lb1[x], in the same cycle.
- Stage 1 (cycle +1):
  - Register r3 = pixel, r2 = lb1 out, r1 = lb2 out, plus x_d and y_d.
  - Row substitution:
    - y_d = 0: r1 = r2 = (BORDER_MODE ? r3 : 0).
    - y_d = 1: r1 = (BORDER_MODE ? r2 : 0).
- Stage 2 (cycle +2), only when the delayed accept is high:
  - x_d = 0: columns 1 and 2 of every row = (BORDER_MODE ? new value : 0); column 3 = new value.
  - x_d = 1: column 1 = (BORDER_MODE ? old column 3 : 0); column 2 = old column 3; column 3 = new.
  - Otherwise: shift left; column 3 = new.
- Delayed href low: all p outputs and matrix_border = 0. Delayed href high with delayed accept low: hold the window.
- matrix_border = (y_d < 2) || (x_d < 2), registered with stage 2.
- Latency: 2 clk from accept to window and from each sync input to its output; independent of parameters.
- clken gaps inside a line: RAM and counters stall, window holds, no bubble corruption.
- Reset asserted mid-frame: outputs 0 immediately. After release, the first line is treated as y = 0 until the next vsync edge, so stale RAM never reaches the outputs.

Test Plan:
1. IMG_W=4, BORDER_MODE=0; pixel(y,x) = 16y+x+1, continuous clken, 3 lines -> at the (y0,x0) output: p33 = 1, all other p = 0, border = 1. At the (y2,x2) output: p11..p13 = 1,2,3; p21..p23 = 17,18,19; p31..p33 = 33,34,35; border = 0.
2. Same stream, BORDER_MODE=1 -> at (y0,x0) all nine = 1. At (y1,x1): p11..p13 = 1,1,2; p21..p23 = 1,1,2; p31..p33 = 17,17,18; border = 1.
3. Latency check: a single accept pulse -> matrix_frame_clken high exactly 2 cycles later. vsync/href edges appear on the outputs exactly 2 cycles later.
4. Random clken gaps (50% duty) within the scenario-1 stream -> windows identical to scenario 1 at each matrix_frame_clken; window held during gaps; 0 when delayed href is low.
5. Overlong line (6 accepts, IMG_W=4) -> accepts 5 and 6 hold the window. The next line's windows still match scenario 1 (RAM not overwritten).
6. rst_n pulsed low during line 2, then a fresh frame -> outputs 0 during reset. The first post-reset window with BORDER_MODE=0 has rows 1 and 2 = 0 despite stale RAM.
